// File: rtl/tiny_alu_seq_pkg.sv
// Shared types and widths for the tiny ALU command sequencer.
package tiny_alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 2 * DATA_W;

  // Opcodes 5..7 are left unnamed on purpose: they are the illegal range.
  typedef enum logic [2:0] {
    NO_OP = 3'd0,
    ADD   = 3'd1,
    AND   = 3'd2,
    XOR   = 3'd3,
    MUL   = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op >= 3'(ADD)) && (op <= 3'(MUL));
  endfunction

endpackage

// File: rtl/tiny_alu_cmd_sequencer_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on the second clock edge.
module tiny_alu_cmd_sequencer_reset_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_n_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rst_n_o = sync_q;

endmodule

// File: rtl/tiny_alu_cmd_sequencer.sv
// Command sequencer in front of the tiny ALU: valid/ready command in, start/done to the ALU,
// valid/ready response out, with a done-timeout and saturating status counters.
//
//   state | meaning
//   IDLE  | ready for a command (once the ALU-side reset has been released)
//   ISSUE | alu_start_o high with op/A/B held, waiting for done or timeout
//   RESP  | response held on the rsp port until rsp_ready_i
module tiny_alu_cmd_sequencer #(
  parameter int DATA_W       = tiny_alu_seq_pkg::DATA_W,
  parameter int RES_W        = tiny_alu_seq_pkg::RES_W,
  parameter int TIMEOUT_CLKS = 16,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  output logic              alu_start_o,
  output logic [2:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic              alu_done_i,
  input  logic [RES_W-1:0]  alu_result_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [RES_W-1:0]  rsp_result_o,
  output logic              rsp_err_o,
  output logic              alu_rst_n_o,
  output logic [CNT_W-1:0]  cmd_count_o,
  output logic [CNT_W-1:0]  err_count_o
);

  import tiny_alu_seq_pkg::*;

  localparam int TMO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT_CLKS - 1);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               accept;

  tiny_alu_cmd_sequencer_reset_sync u_reset_sync (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .rst_n_o (alu_rst_n_o)
  );

  assign cmd_ready_o = (state_q == IDLE) && alu_rst_n_o;
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      cmd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      cmd_cnt_q <= cmd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    cmd_cnt_d = cmd_cnt_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_cnt_q != '1) cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
          if (is_alu_op(cmd_op_i)) begin
            op_d    = cmd_op_i;
            a_d     = cmd_a_i;
            b_d     = cmd_b_i;
            tmo_d   = TMO_INIT;
            state_d = ISSUE;
          end else begin
            // NO_OP and the illegal range both answer directly without touching the ALU.
            result_d = '0;
            err_d    = (cmd_op_i != NO_OP);
            if ((cmd_op_i != NO_OP) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
            state_d  = RESP;
          end
        end
      end
      ISSUE: begin
        // Done is checked before the terminal count so a done in the last cycle wins.
        if (alu_done_i) begin
          result_d = alu_result_i;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (tmo_q == '0) begin
          result_d = '0;
          err_d    = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          state_d  = RESP;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_start_o  = (state_q == ISSUE);
  assign alu_op_o     = op_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_result_o = result_q;
  assign rsp_err_o    = err_q;
  assign cmd_count_o  = cmd_cnt_q;
  assign err_count_o  = err_cnt_q;

endmodule

// File: tb/tb_tiny_alu_cmd_sequencer.sv
// Directed bench for tiny_alu_cmd_sequencer; the ALU side is driven by hand from the stimulus.
// Counters are built 5 bits wide here so that saturation is reachable in a short run.
module tb_tiny_alu_cmd_sequencer;

  localparam int CNT_W = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_a = 8'd0;
  logic [7:0]  cmd_b = 8'd0;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        alu_rst_n;
  logic [CNT_W-1:0] cmd_count;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  logic start_seen = 1'b0;

  tiny_alu_cmd_sequencer #(
    .DATA_W(8), .RES_W(16), .TIMEOUT_CLKS(16), .CNT_W(CNT_W)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .alu_start_o  (alu_start),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_done_i   (alu_done),
    .alu_result_i (alu_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_err_o    (rsp_err),
    .alu_rst_n_o  (alu_rst_n),
    .cmd_count_o  (cmd_count),
    .err_count_o  (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (alu_start) start_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns just after the accepting clock edge.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Done is raised in the k-th cycle that start is high.
  task automatic alu_reply(input int k, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] res);
    @(negedge clk);
    chk("start_rise", {31'd0, alu_start}, 32'd1);
    chk("alu_op", {29'd0, alu_op}, {29'd0, op});
    chk("alu_a", {24'd0, alu_a}, {24'd0, a});
    chk("alu_b", {24'd0, alu_b}, {24'd0, b});
    for (int i = 1; i < k; i++) begin
      @(negedge clk);
      chk("start_held", {31'd0, alu_start}, 32'd1);
    end
    alu_done   = 1'b1;
    alu_result = res;
    @(posedge clk);
    #1;
    alu_done   = 1'b0;
    alu_result = 16'hDEAD;
  endtask

  // Called at the negedge where the response is expected to be valid.
  task automatic take_rsp(input logic [15:0] exp_res, input logic exp_err, input int hold);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_result", {16'd0, rsp_result}, {16'd0, exp_res});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    chk("start_low_resp", {31'd0, alu_start}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_result_hold", {16'd0, rsp_result}, {16'd0, exp_res});
    end
    chk("ready_low_in_resp", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int n;
    logic [CNT_W-1:0] exp_cnt;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", {31'd0, alu_start}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_cmd_count", {27'd0, cmd_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_edge1_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
    @(negedge clk);
    chk("rel_edge2_alu_rst_n", {31'd0, alu_rst_n}, 32'd1);
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: ADD FF+01, done in first start cycle
    send_cmd(3'd1, 8'hFF, 8'h01);
    alu_reply(1, 3'd1, 8'hFF, 8'h01, 16'h0100);
    @(negedge clk);
    take_rsp(16'h0100, 1'b0, 0);
    chk("t1_cmd_count", {27'd0, cmd_count}, 32'd1);

    // 2: MUL FF*FF, done on third start cycle, response back-pressured 5 cycles
    send_cmd(3'd4, 8'hFF, 8'hFF);
    alu_reply(3, 3'd4, 8'hFF, 8'hFF, 16'hFE01);
    @(negedge clk);
    take_rsp(16'hFE01, 1'b0, 5);
    chk("t2_cmd_count", {27'd0, cmd_count}, 32'd2);

    // 3: illegal op then NO_OP; ALU must stay untouched
    start_seen = 1'b0;
    send_cmd(3'd6, 8'h12, 8'h34);
    @(negedge clk);
    take_rsp(16'h0000, 1'b1, 1);
    send_cmd(3'd0, 8'h56, 8'h78);
    @(negedge clk);
    take_rsp(16'h0000, 1'b0, 0);
    chk("t3_no_start", {31'd0, start_seen}, 32'd0);
    chk("t3_err_count", {27'd0, err_count}, 32'd1);
    chk("t3_cmd_count", {27'd0, cmd_count}, 32'd4);

    // 4a: XOR with no done -> 16 start cycles then error response
    send_cmd(3'd3, 8'h5A, 8'h3C);
    n = 0;
    @(negedge clk);
    while (alu_start && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t4_start_cycles", n, 32'd16);
    take_rsp(16'h0000, 1'b1, 0);
    chk("t4_err_count", {27'd0, err_count}, 32'd2);

    // 4b: done in the last counted cycle beats the timeout
    send_cmd(3'd3, 8'h5A, 8'h3C);
    alu_reply(16, 3'd3, 8'h5A, 8'h3C, 16'h0066);
    @(negedge clk);
    take_rsp(16'h0066, 1'b0, 0);
    chk("t4b_err_count", {27'd0, err_count}, 32'd2);
    chk("t4b_cmd_count", {27'd0, cmd_count}, 32'd6);

    // 5: reset for 3 clocks while in ISSUE
    send_cmd(3'd2, 8'hF0, 8'h3C);
    @(negedge clk);
    chk("t5_in_issue", {31'd0, alu_start}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_start_drop", {31'd0, alu_start}, 32'd0);
    chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
    chk("t5_cmd_count", {27'd0, cmd_count}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_edge1_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
    chk("t5_edge1_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("t5_edge2_alu_rst_n", {31'd0, alu_rst_n}, 32'd1);
    chk("t5_edge2_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("t5_no_start", {31'd0, alu_start}, 32'd0);

    // 6: spurious done in IDLE, then drive both counters into saturation
    alu_done   = 1'b1;
    alu_result = 16'hBEEF;
    @(negedge clk);
    alu_done   = 1'b0;
    @(negedge clk);
    chk("t6_idle_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("t6_idle_start", {31'd0, alu_start}, 32'd0);
    chk("t6_idle_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 1; i <= 33; i++) begin
      send_cmd(3'd7, 8'h00, 8'h00);
      @(negedge clk);
      take_rsp(16'h0000, 1'b1, 0);
      exp_cnt = (i > 31) ? 5'h1F : CNT_W'(i);
      chk("t6_cmd_count", {27'd0, cmd_count}, {27'd0, exp_cnt});
      chk("t6_err_count", {27'd0, err_count}, {27'd0, exp_cnt});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
